// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. Segment k of the WIDTH-bit operation is resolved
// in stage k, and the carry is registered between stages. The output uses a valid/ready handshake.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG_W;

  // Level k holds the operation before segment k is resolved. In r_x, the segments
  // below k already hold sum bits, and the segments from k upward still hold operand A.
  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_x [STAGES];
  logic [WIDTH-1:0] r_y [STAGES];
  logic             r_c [STAGES];

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;

  logic [SEG_W:0]   w_seg   [STAGES];
  logic [WIDTH-1:0] w_x_nxt [STAGES];
  logic             w_c_nxt [STAGES];
  logic             w_stall;
  logic             w_cin_msb;
  logic             w_ovf;
  logic             w_zero;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * SEG_W;
      localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_W{1'b1}}) << LO;

      assign w_seg[gi]   = {1'b0, r_x[gi][LO +: SEG_W]} + {1'b0, r_y[gi][LO +: SEG_W]}
                         + {{SEG_W{1'b0}}, r_c[gi]};
      assign w_x_nxt[gi] = (r_x[gi] & ~SEG_MASK) | (WIDTH'(w_seg[gi][SEG_W-1:0]) << LO);
      assign w_c_nxt[gi] = w_seg[gi][SEG_W];
    end
  endgenerate

  // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  assign w_cin_msb = w_x_nxt[STAGES-1][WIDTH-1] ^ r_x[STAGES-1][WIDTH-1]
                   ^ r_y[STAGES-1][WIDTH-1];
  assign w_ovf     = w_cin_msb ^ w_c_nxt[STAGES-1];
  assign w_zero    = (w_x_nxt[STAGES-1] == '0);

  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = ~w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k] <= 1'b0;
        r_x[k] <= '0;
        r_y[k] <= '0;
        r_c[k] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (!w_stall) begin
      r_v[0] <= in_valid;
      r_x[0] <= a;
      r_y[0] <= sub ? ~b : b;
      r_c[0] <= sub ? 1'b1 : cin;
      for (int k = 1; k < STAGES; k++) begin
        r_v[k] <= r_v[k-1];
        r_x[k] <= w_x_nxt[k-1];
        r_y[k] <= r_y[k-1];
        r_c[k] <= w_c_nxt[k-1];
      end
      r_out_valid <= r_v[STAGES-1];
      // The result registers keep the last real result, so bubbles never disturb the flags.
      if (r_v[STAGES-1]) begin
        r_sum   <= w_x_nxt[STAGES-1];
        r_carry <= w_c_nxt[STAGES-1];
        r_ovf   <= w_ovf;
        r_zero  <= w_zero;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit; successor to the fixed 32-bit two-level CLA adder.
- The WIDTH-bit operation is split into SEG_W-bit segments. Each segment is resolved in its own pipeline stage, with the carry registered between stages.
- Adds subtract mode, valid/ready handshake with backpressure, and status flags (carry, signed overflow, zero).
- Sits between the operand source (register file / ALU input mux) and the ALU result path.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SEG_W.
- SEG_W, 16, segment width resolved per stage (combinational CLA inside); STAGES = WIDTH/SEG_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1 = compute a - b (b inverted, cin forced to 1; cin port ignored)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- carry  output  1  carry out of MSB (in sub mode, 1 = no borrow)
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

Behaviour:
- Reset, synchronous on a rising edge with reset=1:
  - All stage valid bits clear.
  - out_valid=0; sum, carry, overflow and zero are 0.
  - Any in-flight operations are discarded; nothing reaches the output after reset.
- Stall and transfer:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - An input transfer occurs when in_valid & in_ready at a clock edge.
- Pipeline advance:
  - When stall=0, every stage register loads from its predecessor on each edge. Stage 0 loads the input operands and their valid bit.
  - When stall=1, all stages hold.
  - Bubbles are not compressed; the whole pipeline freezes together.
- Stage k (0..STAGES-1):
  - Adds segment k of a and b' (b' = sub ? ~b : b) plus the carry from stage k-1. Stage 0 uses sub ? 1 : cin.
  - Registers the resulting segment sum and carry.
  - Carries forward the unused upper operand segments and the already computed lower sum segments.
- Latency:
  - An operation accepted at edge n has out_valid=1 after edge n+STAGES.
  - Throughput is one operation per cycle when out_ready=1.
- Output stage:
  - sum, carry, overflow and zero are registered together with out_valid.
  - They stay stable while out_valid & ~out_ready.
  - overflow uses the carry into bit WIDTH-1 (internal) and the final carry.
- Result values are exact modulo 2^WIDTH.
  - Add: sum = a + b + cin.
  - Sub: sum = a + ~b + 1.
- Handshake guarantees:
  - in_valid with in_ready=0 captures nothing; the source holds its operands.
  - Simultaneous out_valid & out_ready with a new in_valid on the same edge: the result is consumed and the input is accepted; no loss.
  - The sub and cin fields of each operation travel with it; mixed add/sub back-to-back streams are legal.
- Reset asserted mid-stream:
  - Takes priority over all transfers that cycle.
  - in_ready is 1 in the cycle after reset deasserts.
- SEG_W = WIDTH gives STAGES=1, a single-cycle registered adder with the same handshake.

Test Plan:
1. Reset check (WIDTH=32, SEG_W=16): hold reset 2 cycles, then release -> out_valid=0, sum=0, carry=0, overflow=0, zero=0, in_ready=1.
2. Add with cross-segment carry: a=0x0000FFFF, b=0x00000001, cin=0, sub=0 -> after 2 cycles sum=0x00010000, carry=0, overflow=0, zero=0.
3. Sub to zero, then overflow:
   - a=0x12345678, b=0x12345678, sub=1 -> sum=0, zero=1, carry=1.
   - a=0x7FFFFFFF, b=0xFFFFFFFF, sub=1 -> sum=0x80000000, overflow=1, carry=0.
4. Backpressure: stream 6 back-to-back adds (i + 1, i=0..5) with out_ready low on cycles 3-5 -> in_ready low exactly while out_valid & ~out_ready; results 1..6 in order; no duplicates or drops.
5. Reset mid-operation: accept 2 operations, assert reset for 1 cycle before they reach the output -> neither result ever appears; out_valid stays 0 until a new operation is accepted.
6. Parameter sweep (WIDTH=64, SEG_W=8, so STAGES=8):
   - Directed case a=0xFFFFFFFFFFFFFFFF, b=1 -> sum=0, carry=1, zero=1, latency 8 cycles.
   - 1000 random mixed add/sub operations checked against a reference model.
